traffic_intersection_ctrl: RTL and testbench

Parametrised multi-approach intersection controller that replaces the fixed three-state single-signal light. It serves NUM_DIR approaches in round-robin order. Each approach gets a green phase, a yellow phase and an all-red clearance phase, all with tick-based durations set by parameters. It also latches pedestrian walk requests and provides a fail-safe flashing-red mode. It sits between the board clock and the LED/pin drivers, one red/yellow/green/walk bit per approach.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/traffic_tick_gen.sv | 32 +++
 rtl/traffic_intersection_ctrl.sv | 163 ++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | traffic_pkg: phase encoding and timer sizing for the intersection     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_FLASH   = 2'd3
  } phase_t;

  // One spare bit above what the longest phase needs.
  function automatic int timer_width(input int g, input int y, input int a,
                                     input int p, input int f);
    int m;
    m = g;
    if (y > m) m = y;
    if (a > m) m = a;
    if (p > m) m = p;
    if (f > m) m = f;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | traffic_tick_gen: one-cycle tick every TICK_DIV clock cycles          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module traffic_tick_gen #(
  parameter int TICK_DIV = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | traffic_intersection_ctrl: round-robin multi-approach light with      |
// | pedestrian walk latching and fail-safe flashing red.  Rev 1.0         |
// +-----------------------------------------------------------------------+
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 4,
  parameter int TICK_DIV     = 27_000_000,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 8,
  parameter int FLASH_TICKS  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIR-1:0]         ped_req,
  input  logic                       flash_en,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [NUM_DIR-1:0]         walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic                       flashing
);

  localparam int c_DW    = $clog2(NUM_DIR);
  localparam int c_SRV   = (PED_TICKS > GREEN_TICKS) ? PED_TICKS : GREEN_TICKS;
  localparam int c_TW    = timer_width(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS,
                                       PED_TICKS, FLASH_TICKS);
  localparam logic [c_TW-1:0] c_G_LAST   = c_TW'(GREEN_TICKS - 1);
  localparam logic [c_TW-1:0] c_SRV_LAST = c_TW'(c_SRV - 1);
  localparam logic [c_TW-1:0] c_Y_LAST   = c_TW'(YELLOW_TICKS - 1);
  localparam logic [c_TW-1:0] c_A_LAST   = c_TW'(ALLRED_TICKS - 1);
  localparam logic [c_TW-1:0] c_F_LAST   = c_TW'(FLASH_TICKS - 1);
  localparam logic [c_DW-1:0] c_DIR_LAST = c_DW'(NUM_DIR - 1);

  phase_t             r_state;
  logic [c_TW-1:0]    r_timer;
  logic [c_DW-1:0]    r_dir;
  logic               r_fresh;   // next green restarts at approach 0
  logic               r_served;
  logic               r_blink;
  logic [NUM_DIR-1:0] r_pend;

  logic               w_tick;
  logic [c_DW-1:0]    w_next_dir;
  logic               w_entry_served;
  logic               w_green_entry;
  logic [c_TW-1:0]    w_green_last;
  logic [NUM_DIR-1:0] w_pend_clr;

  traffic_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_next_dir     = r_fresh ? '0 : ((r_dir == c_DIR_LAST) ? '0 : r_dir + 1'b1);
  assign w_entry_served = r_pend[w_next_dir] | ped_req[w_next_dir];
  assign w_green_entry  = w_tick && (r_state == PH_ALL_RED) &&
                          (r_timer == c_A_LAST) && !flash_en;
  assign w_green_last   = r_served ? c_SRV_LAST : c_G_LAST;
  // A request on the entry edge is consumed, not re-latched.
  assign w_pend_clr     = w_green_entry ? (NUM_DIR'(1) << w_next_dir) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PH_ALL_RED;
      r_timer  <= '0;
      r_dir    <= '0;
      r_fresh  <= 1'b1;
      r_served <= 1'b0;
      r_blink  <= 1'b0;
      r_pend   <= '0;
    end else begin
      r_pend <= (r_pend | ped_req) & ~w_pend_clr;
      if (w_tick) begin
        case (r_state)
          PH_ALL_RED: begin
            if (r_timer == c_A_LAST) begin
              r_timer <= '0;
              if (flash_en) begin
                r_state <= PH_FLASH;
                r_blink <= 1'b1;
              end else begin
                r_state  <= PH_GREEN;
                r_dir    <= w_next_dir;
                r_fresh  <= 1'b0;
                r_served <= w_entry_served;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          PH_GREEN: begin
            if (flash_en || (r_timer == w_green_last)) begin
              r_state <= PH_YELLOW;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          PH_YELLOW: begin
            if (r_timer == c_Y_LAST) begin
              r_state <= PH_ALL_RED;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          PH_FLASH: begin
            if (!flash_en) begin
              r_state <= PH_ALL_RED;
              r_timer <= '0;
              r_fresh <= 1'b1;
            end else if (r_timer == c_F_LAST) begin
              r_timer <= '0;
              r_blink <= ~r_blink;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          default: begin
            r_state <= PH_ALL_RED;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    walk   = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      case (r_state)
        PH_GREEN: begin
          red[i]   = (c_DW'(i) != r_dir);
          green[i] = (c_DW'(i) == r_dir);
          walk[i]  = (c_DW'(i) == r_dir) & r_served;
        end
        PH_YELLOW: begin
          red[i]    = (c_DW'(i) != r_dir);
          yellow[i] = (c_DW'(i) == r_dir);
        end
        PH_FLASH: red[i] = r_blink;
        default:  red[i] = 1'b1;
      endcase
    end
  end

  assign active_dir = r_dir;
  assign flashing   = (r_state == PH_FLASH);

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// Bench for traffic_intersection_ctrl: vector table, corner sequences and a
// random run against a time-based reference model.
module tb_traffic_intersection_ctrl;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int G  = 5;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int P  = 8;
  localparam int F  = 3;
  localparam int GS = (P > G) ? P : G;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ped_req = '0;
  logic         flash_en = 1'b0;
  logic [N-1:0] red, yellow, green, walk;
  logic [1:0]   active_dir;
  logic         flashing;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 1'b0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .NUM_DIR (N), .TICK_DIV (TD), .GREEN_TICKS (G), .YELLOW_TICKS (Y),
    .ALLRED_TICKS (A), .PED_TICKS (P), .FLASH_TICKS (F)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ped_req (ped_req), .flash_en (flash_en),
    .red (red), .yellow (yellow), .green (green), .walk (walk),
    .active_dir (active_dir), .flashing (flashing)
  );

  // Reference model: phases tracked by absolute start cycle; 0=all-red 1=green 2=yellow 3=flash
  int           m_phase, m_dir, m_start, m_fstart, mc, mdone, mnd;
  bit           m_fresh, m_served, mtk;
  logic [N-1:0] m_pend, mnew;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_dir = 0; m_start = 0; m_fstart = 0;
      m_fresh = 1; m_served = 0; m_pend = '0; cyc = 0;
    end else begin
      mc    = cyc;
      mtk   = (mc % TD) == TD - 1;
      mdone = (mc + 1 - m_start) / TD;
      mnew  = m_pend | ped_req;
      if (mtk) begin
        case (m_phase)
          0: if (mdone == A) begin
               if (flash_en) begin
                 m_phase = 3; m_fstart = mc + 1;
               end else begin
                 mnd = m_fresh ? 0 : (m_dir + 1) % N;
                 m_served = m_pend[mnd] | ped_req[mnd];
                 mnew[mnd] = 1'b0;
                 m_dir = mnd; m_fresh = 0; m_phase = 1;
               end
               m_start = mc + 1;
             end
          1: if (flash_en || mdone == (m_served ? GS : G)) begin
               m_phase = 2; m_start = mc + 1;
             end
          2: if (mdone == Y) begin
               m_phase = 0; m_start = mc + 1;
             end
          default: if (!flash_en) begin
               m_phase = 0; m_fresh = 1; m_start = mc + 1;
             end
        endcase
      end
      m_pend = mnew;
      cyc = mc + 1;
    end
  end

  function automatic logic [12:0] model_lamps();
    logic [N-1:0] oh, r, y, g, w;
    oh = N'(1) << m_dir;
    r = '1; y = '0; g = '0; w = '0;
    case (m_phase)
      1: begin r = ~oh; g = oh; w = m_served ? oh : '0; end
      2: begin r = ~oh; y = oh; end
      3: r = ((((cyc - m_fstart) / (F * TD)) % 2) == 0) ? '1 : '0;
      default: r = '1;
    endcase
    return {r, y, g, w, (m_phase == 3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (sb_en) begin
      check("sb_lamps", {red, yellow, green, walk, flashing}, model_lamps());
      if (m_phase == 1 || m_phase == 2) check("sb_dir", active_dir, m_dir);
    end
  end

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      checks++; failures++;
      $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
    end
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; ped_req = '0; flash_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {red, yellow, green, walk, flashing, active_dir},
          {3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int           c;
    logic [N-1:0] r;
    logic [N-1:0] y;
    logic [N-1:0] g;
    int           d;   // -1: active_dir not checked
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0,   3'b111, 3'b000, 3'b000, 0};
    tbl[1]  = '{3,   3'b111, 3'b000, 3'b000, 0};
    tbl[2]  = '{4,   3'b110, 3'b000, 3'b001, 0};
    tbl[3]  = '{23,  3'b110, 3'b000, 3'b001, 0};
    tbl[4]  = '{24,  3'b110, 3'b001, 3'b000, 0};
    tbl[5]  = '{31,  3'b110, 3'b001, 3'b000, 0};
    tbl[6]  = '{32,  3'b111, 3'b000, 3'b000, -1};
    tbl[7]  = '{35,  3'b111, 3'b000, 3'b000, -1};
    tbl[8]  = '{36,  3'b101, 3'b000, 3'b010, 1};
    tbl[9]  = '{55,  3'b101, 3'b000, 3'b010, 1};
    tbl[10] = '{56,  3'b101, 3'b010, 3'b000, 1};
    tbl[11] = '{64,  3'b111, 3'b000, 3'b000, -1};
    tbl[12] = '{68,  3'b011, 3'b000, 3'b100, 2};
    tbl[13] = '{88,  3'b011, 3'b100, 3'b000, 2};
    tbl[14] = '{96,  3'b111, 3'b000, 3'b000, -1};
    tbl[15] = '{100, 3'b110, 3'b000, 3'b001, 0};

    sb_en = 1'b1;

    // Plain round-robin from reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_cyc(tbl[i].c);
      check("vec_lamps", {red, yellow, green, walk, flashing},
            {tbl[i].r, tbl[i].y, tbl[i].g, 3'b000, 1'b0});
      if (tbl[i].d >= 0) check("vec_dir", active_dir, tbl[i].d);
    end

    // Pedestrian pulse and held request
    do_reset();
    wait_cyc(10); ped_req = 3'b010;
    wait_cyc(11); ped_req = 3'b000;
    wait_cyc(36);  check("ped1_walk_start", {green, walk}, {3'b010, 3'b010});
    wait_cyc(67);  check("ped1_walk_end", {green, walk}, {3'b010, 3'b010});
    wait_cyc(68);  check("ped1_yellow", {yellow, walk}, {3'b010, 3'b000});
    wait_cyc(70);  ped_req = 3'b100;
    wait_cyc(80);  check("ped2_walk", {green, walk}, {3'b100, 3'b100});
    wait_cyc(90);  ped_req = 3'b000;
    wait_cyc(111); check("ped2_long_green", green, 3'b100);
    wait_cyc(112); check("ped2_yellow", yellow, 3'b100);
    wait_cyc(156); check("ped1_cleared", {green, walk}, {3'b010, 3'b000});
    wait_cyc(188); check("ped2_relatched", {green, walk}, {3'b100, 3'b100});

    // Flash entry, blinking, exit with pending walk
    do_reset();
    wait_cyc(6);  flash_en = 1'b1;
    wait_cyc(8);  check("fl_yellow0", {yellow, green}, {3'b001, 3'b000});
    wait_cyc(15); check("fl_yellow0_end", yellow, 3'b001);
    wait_cyc(16); check("fl_allred", {red, flashing}, {3'b111, 1'b0});
    wait_cyc(20); check("fl_enter", {red, yellow, green, flashing}, {3'b111, 6'b0, 1'b1});
    wait_cyc(30); ped_req = 3'b001;
    wait_cyc(31); ped_req = 3'b000; check("fl_on_end", red, 3'b111);
    wait_cyc(32); check("fl_off", {red, flashing}, {3'b000, 1'b1});
    wait_cyc(44); check("fl_on_again", red, 3'b111);
    wait_cyc(50); flash_en = 1'b0;
    wait_cyc(52); check("fl_exit_allred", {red, flashing}, {3'b111, 1'b0});
    wait_cyc(56); check("fl_exit_green0", {green, walk, active_dir}, {3'b001, 3'b001, 2'd0});
    wait_cyc(87); check("fl_served_green", green, 3'b001);
    wait_cyc(88); check("fl_served_yellow", yellow, 3'b001);

    // Asynchronous reset in the middle of yellow[1]
    do_reset();
    wait_cyc(58); check("mid_yellow1", yellow, 3'b010);
    #2; rst_n = 1'b0; #1;
    check("async_rst", {red, yellow, green, walk, flashing, active_dir},
          {3'b111, 9'b0, 1'b0, 2'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3); check("restart_allred", {red, green}, {3'b111, 3'b000});
    wait_cyc(4); check("restart_green0", {green, active_dir}, {3'b001, 2'd0});

    // Random traffic against the model
    do_reset();
    for (int k = 1; k <= 3000; k++) begin
      wait_cyc(k);
      for (int i = 0; i < N; i++) ped_req[i] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) flash_en = ~flash_en;
    end

    sb_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
